// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and counter width.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Applies operand signs to the unsigned quotient/remainder of a magnitude division.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] q_raw_i,
  input  logic [WIDTH-1:0] r_raw_i,
  input  logic             a_neg_i,
  input  logic             b_neg_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o
);

  always_comb begin
    q_o = (a_neg_i ^ b_neg_i) ? -q_raw_i : q_raw_i;
    r_o = a_neg_i ? -r_raw_i : r_raw_i;
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with
// start/busy/done handshake. Optional zero-operand shortcut: MD_EARLY_ZERO_EN.
module mult_div_seq
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int W = WIDTH;

  md_state_e        state_q;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W:0]     acc_q;
  logic [W-1:0]     opb_q;
  logic             a_neg_q, b_neg_q;
  logic             busy_q, done_q, div_zero_q;
  logic [W-1:0]     hi_q, lo_q;

  logic             accept, early_zero;
  logic [W-1:0]     a_mag, b_mag;
  logic [W-1:0]     booth_hi;
  logic [W:0]       booth_sum, div_sh, div_diff;
  logic [2*W:0]     booth_nxt, div_nxt;
  logic [W-1:0]     q_fix, r_fix;

  // Booth view of acc_q: {hi[W], lo[W], q-1}; divide view: {rem[W+1], quotient[W]}.
  always_comb begin
    accept = (state_q == S_IDLE || state_q == S_DONE) && start &&
             (op == MD_MULT || op == MD_DIV);
`ifdef MD_EARLY_ZERO_EN
    early_zero = (op == MD_MULT && (a_in == '0 || b_in == '0)) ||
                 (op == MD_DIV && a_in == '0 && b_in != '0);
`else
    early_zero = 1'b0;
`endif
    a_mag    = a_in[W-1] ? -a_in : a_in;
    b_mag    = b_in[W-1] ? -b_in : b_in;
    booth_hi = acc_q[2*W:W+1];
    case (acc_q[1:0])
      2'b01:   booth_sum = {booth_hi[W-1], booth_hi} + {opb_q[W-1], opb_q};
      2'b10:   booth_sum = {booth_hi[W-1], booth_hi} - {opb_q[W-1], opb_q};
      default: booth_sum = {booth_hi[W-1], booth_hi};
    endcase
    booth_nxt = {booth_sum, acc_q[W:1]};
    div_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_sh - {1'b0, opb_q};
    div_nxt   = div_diff[W] ? {div_sh, acc_q[W-2:0], 1'b0}
                            : {div_diff, acc_q[W-2:0], 1'b1};
  end

  md_sign_fix #(.WIDTH(W)) u_sign_fix (
    .q_raw_i (acc_q[W-1:0]),
    .r_raw_i (acc_q[2*W-1:W]),
    .a_neg_i (a_neg_q),
    .b_neg_i (b_neg_q),
    .q_o     (q_fix),
    .r_o     (r_fix)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= MD_NONE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (!accept) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (op == MD_DIV && b_in == '0) begin
            op_q       <= MD_DIV;
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end else if (early_zero) begin
            op_q    <= md_op_e'(op);
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
          end else begin
            op_q    <= md_op_e'(op);
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(W - 1);
            a_neg_q <= a_in[W-1];
            b_neg_q <= b_in[W-1];
            if (op == MD_MULT) begin
              opb_q <= a_in;
              acc_q <= {{W{1'b0}}, b_in, 1'b0};
            end else begin
              opb_q <= b_mag;
              acc_q <= {{(W+1){1'b0}}, a_mag};
            end
          end
        end
        S_RUN: begin
          acc_q <= (op_q == MD_MULT) ? booth_nxt : div_nxt;
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_FIX: begin
          if (op_q == MD_MULT) begin
            hi_q <= acc_q[2*W:W+1];
            lo_q <= acc_q[W:1];
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed corner cases plus random
// operations against an arithmetic reference model.
module tb_mult_div_seq;

  localparam int WIDTH = 32;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, done, div_zero;
  logic [WIDTH-1:0] hi_out, lo_out;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz;
  int          exp_lat;

  always #5 clk = ~clk;

  mult_div_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Reference: signed 64-bit product, or truncating signed division with the
  // remainder carrying the dividend's sign; divide-by-zero leaves HI/LO alone.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_dz  = 1'b0;
    exp_lat = 33;
    if (o == OP_MULT) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == 32'd0) begin
      exp_dz  = 1'b1;
      exp_lat = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_hi = r[31:0];
      exp_lo = q[31:0];
    end
`ifdef MD_EARLY_ZERO_EN
    if ((o == OP_MULT && (a == 0 || b == 0)) || (o == OP_DIV && a == 0 && b != 0))
      exp_lat = 0;
`endif
  endtask

  // Called away from a clock edge; the next rising edge is the accept edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    int lat, nbusy;
    model(o, a, b);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00;
    lat = 0;
    nbusy = int'(busy);
    while (!done && lat < 60) begin
      if (poke && lat == 5) begin
        start = 1'b1; op = OP_MULT; a_in = $urandom; b_in = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      nbusy += int'(busy);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("done", 64'(done), 64'd1);
    check("div_zero", 64'(div_zero), 64'(exp_dz));
    check("hi", 64'(hi_out), 64'(exp_hi));
    check("lo", 64'(lo_out), 64'(exp_lo));
    check("busy_cycles", 64'(nbusy), (exp_lat == 0) ? 64'd0 : 64'd33);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("dz_low", 64'(div_zero), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("hold_hi", 64'(hi_out), 64'(exp_hi));
    check("hold_lo", 64'(lo_out), 64'(exp_lo));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b1;
    idle_cycle();

    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("t1_hi", 64'(hi_out), 64'hFFFF_FFFF);
    check("t1_lo", 64'(lo_out), 64'hFFFF_FFEB);
    idle_cycle();
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("t2_hi", 64'(hi_out), 64'h4000_0000);
    idle_cycle();
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("t3a_lo", 64'(lo_out), 64'hFFFF_FFFD);
    check("t3a_hi", 64'(hi_out), 64'hFFFF_FFFF);
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check("t3b_hi", 64'(hi_out), 64'd1);
    idle_cycle();
    do_op(OP_MULT, 32'd3, 32'd5, 1'b0);
    idle_cycle();
    do_op(OP_DIV, 32'd5, 32'd0, 1'b0);
    check("t4_lo", 64'(lo_out), 64'd15);
    idle_cycle();
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("t5_lo", 64'(lo_out), 64'h8000_0000);
    idle_cycle();

    // Reserved and none opcodes must not start anything.
    start = 1'b1; op = 2'b11; a_in = 32'd9; b_in = 32'd9;
    @(posedge clk); #1;
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_done", 64'(done), 64'd0);
    op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    check("none_busy", 64'(busy), 64'd0);
    idle_cycle();

    // Reset during the 10th RUN cycle discards everything.
    start = 1'b1; op = OP_MULT; a_in = 32'd1234; b_in = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    idle_cycle();

    // Back-to-back: second start lands in the DONE cycle of the first.
    do_op(OP_MULT, 32'hFFFF_FF00, 32'd300, 1'b0);
    do_op(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b0);
    do_op(OP_DIV, 32'd1, 32'd0, 1'b0);
    do_op(OP_MULT, 32'd0, 32'hDEAD_BEEF, 1'b0);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = '0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF);
        default: ;
      endcase
      do_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
